// File: rtl/cfg_bank_pkg.sv
// Shared types and constants for the BL/WL configuration bank driver.
package cfg_bank_pkg;

  localparam int unsigned DefBlW   = 315;
  localparam int unsigned DefWlW   = 4;
  localparam int unsigned DefDataW = 32;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSetup,
    StPulse,
    StHold,
    StDone
  } state_e;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/bl_frame_assembler.sv
// Assembles configuration words into the BL frame register; the last word is clipped at BL_W.
module bl_frame_assembler
  import cfg_bank_pkg::*;
#(
  parameter int unsigned BL_W   = DefBlW,
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_data,
  output logic [BL_W-1:0]   o_bl,
  output logic              o_last_word
);

  localparam int unsigned NW    = ceil_div(BL_W, DATA_W);
  localparam int unsigned WordW = (NW > 1) ? $clog2(NW + 1) : 1;

  logic [WordW-1:0] r_word;
  logic [BL_W-1:0]  r_bl;
  logic [BL_W-1:0]  w_bl_next;

  // Each frame bit belongs to exactly one word slot; bits past BL_W simply do not exist.
  for (genvar gi = 0; gi < BL_W; gi++) begin : g_bit
    assign w_bl_next[gi] = (i_wr_en && (r_word == WordW'(gi / DATA_W))) ?
                           i_data[gi % DATA_W] : r_bl[gi];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_word <= '0;
      r_bl   <= '0;
    end else begin
      r_bl <= w_bl_next;
      if (i_clear) begin
        r_word <= '0;
      end else if (i_wr_en) begin
        r_word <= r_word + 1'b1;
      end
    end
  end

  assign o_bl        = r_bl;
  assign o_last_word = (r_word == WordW'(NW - 1));

endmodule

// File: rtl/bl_wl_prog_driver.sv
// Programs the BL/WL bank row by row: load a BL frame, then fire a timed one-hot WL pulse.
module bl_wl_prog_driver
  import cfg_bank_pkg::*;
#(
  parameter int unsigned BL_W         = DefBlW,
  parameter int unsigned WL_W         = DefWlW,
  parameter int unsigned DATA_W       = DefDataW,
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned PULSE_CYCLES = 2,
  localparam int unsigned RowW        = (WL_W > 1) ? $clog2(WL_W) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic [BL_W-1:0]   bl_out,
  output logic [WL_W-1:0]   wl_out,
  output logic              busy,
  output logic              done,
  output logic [RowW-1:0]   row_idx
);

  localparam int unsigned TMax   = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int unsigned TimerW = (TMax > 1) ? $clog2(TMax) : 1;

  state_e            r_state;
  logic [TimerW-1:0] r_timer;
  logic [RowW-1:0]   r_row;
  logic [WL_W-1:0]   r_wl;

  logic            w_accept;
  logic            w_clear;
  logic            w_last_word;
  logic [WL_W-1:0] w_row_onehot;

  assign w_accept     = (r_state == StLoad) && cfg_valid;
  assign w_clear      = (r_state != StLoad);
  assign w_row_onehot = WL_W'(1) << r_row;

  bl_frame_assembler #(
    .BL_W  (BL_W),
    .DATA_W(DATA_W)
  ) u_frame (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_clear    (w_clear),
    .i_wr_en    (w_accept),
    .i_data     (cfg_data),
    .o_bl       (bl_out),
    .o_last_word(w_last_word)
  );

  // WL is set on entry to PULSE and cleared on exit, so it is only ever high in PULSE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= StIdle;
      r_timer <= '0;
      r_row   <= '0;
      r_wl    <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start) begin
            r_state <= StLoad;
            r_row   <= '0;
          end
        end
        StLoad: begin
          if (w_accept && w_last_word) begin
            r_state <= StSetup;
            r_timer <= '0;
          end
        end
        StSetup: begin
          if (r_timer == TimerW'(SETUP_CYCLES - 1)) begin
            r_state <= StPulse;
            r_timer <= '0;
            r_wl    <= w_row_onehot;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        StPulse: begin
          if (r_timer == TimerW'(PULSE_CYCLES - 1)) begin
            r_state <= StHold;
            r_wl    <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        StHold: begin
          if (r_row == RowW'(WL_W - 1)) begin
            r_state <= StDone;
          end else begin
            r_row   <= r_row + 1'b1;
            r_state <= StLoad;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
          r_wl    <= '0;
        end
      endcase
    end
  end

  assign cfg_ready = (r_state == StLoad);
  assign busy      = (r_state != StIdle);
  assign done      = (r_state == StDone);
  assign wl_out    = r_wl;
  assign row_idx   = r_row;

endmodule
